vga_timing_gen: RTL

- Parametrised raster timing generator; successor to the fixed 640x480 counter block.
- Produces horizontal/vertical counters, sync pulses with configurable polarity, a display-enable, active-area pixel coordinates, and line/frame start strobes.
- Sits between the pixel clock domain and the game renderer/pixel mux.
- Supports any mode expressible as sync/back-porch/active/front-porch, and a pixel clock-enable so it can run from a faster system clock.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_axis_counter.sv | 75 +++++++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, sync polarity enum and mode-legality helpers
// for the raster timing generator.
package vga_pkg;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int        VGA640_H_SYNC   = 96;
    localparam int        VGA640_H_BP     = 48;
    localparam int        VGA640_H_ACTIVE = 640;
    localparam int        VGA640_H_FP     = 16;
    localparam int        VGA640_V_SYNC   = 2;
    localparam int        VGA640_V_BP     = 33;
    localparam int        VGA640_V_ACTIVE = 480;
    localparam int        VGA640_V_FP     = 10;
    localparam sync_pol_e VGA640_H_POL    = SYNC_ACTIVE_LOW;
    localparam sync_pol_e VGA640_V_POL    = SYNC_ACTIVE_LOW;

    // 800x600@72, 50 MHz pixel clock
    localparam int        SVGA800_H_SYNC   = 120;
    localparam int        SVGA800_H_BP     = 64;
    localparam int        SVGA800_H_ACTIVE = 800;
    localparam int        SVGA800_H_FP     = 56;
    localparam int        SVGA800_V_SYNC   = 6;
    localparam int        SVGA800_V_BP     = 23;
    localparam int        SVGA800_V_ACTIVE = 600;
    localparam int        SVGA800_V_FP     = 37;
    localparam sync_pol_e SVGA800_H_POL    = SYNC_ACTIVE_HIGH;
    localparam sync_pol_e SVGA800_V_POL    = SYNC_ACTIVE_HIGH;

    function automatic int seg_total(input int s, input int b,
                                     input int a, input int f);
        return s + b + a + f;
    endfunction

    function automatic bit seg_legal(input int s, input int b,
                                     input int a, input int f,
                                     input int cw);
        return (s >= 1) && (b >= 1) && (a >= 1) && (f >= 1) &&
               (cw >= 1) && (cw <= 30) &&
               (seg_total(s, b, a, f) < (1 << cw));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter plus sync/active decode of its next value.
// Lookahead decode is present only with VGA_TIMING_LOOKAHEAD_EN.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int CW     = 10,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int FP     = 16
) (
    input  logic          dclk,
    input  logic          clr_n,
    input  logic          adv,
`ifdef VGA_TIMING_LOOKAHEAD_EN
    input  logic          la_adv,
    output logic          nlast,
    output logic          la_act,
    output logic [CW-1:0] la_pos,
`endif
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          n_sync,
    output logic          n_act,
    output logic [CW-1:0] n_pos
);

    localparam int TOTAL = seg_total(SYNC, BP, ACTIVE, FP);

    if (!seg_legal(SYNC, BP, ACTIVE, FP, CW)) begin : g_bad_mode
        $error("vga_axis_counter: illegal segment lengths for CW");
    end

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SEND = CW'(SYNC);
    localparam logic [CW-1:0] A0   = CW'(SYNC + BP);
    localparam logic [CW-1:0] A1   = CW'(SYNC + BP + ACTIVE);

    logic [CW-1:0] nxt;

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

    always_comb begin
        wrap = adv && (cnt == LAST);
        nxt  = cnt;
        if (adv) begin
            nxt = wrap ? '0 : cnt + 1'b1;
        end
        n_sync = (nxt < SEND);
        n_act  = (nxt >= A0) && (nxt < A1);
        n_pos  = n_act ? nxt - A0 : '0;
    end

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [CW-1:0] succ;

    // Position one advance beyond nxt; V only steps when H is about to wrap.
    always_comb begin
        nlast = (nxt == LAST);
        succ  = nxt;
        if (la_adv) begin
            succ = nlast ? '0 : nxt + 1'b1;
        end
        la_act = (succ >= A0) && (succ < A1);
        la_pos = la_act ? succ - A0 : '0;
    end
`endif

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator; VGA_TIMING_LOOKAHEAD_EN adds
// one-pixel-ahead nde/nx/ny for synchronous RAM reads.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CW       = 10,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter bit H_POL    = VGA640_H_POL,
    parameter bit V_POL    = VGA640_V_POL
) (
    input  logic          dclk,
    input  logic          clr_n,
    input  logic          ce,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_LOOKAHEAD_EN
    ,
    output logic          nde,
    output logic [CW-1:0] nx,
    output logic [CW-1:0] ny
`endif
);

    logic          h_wrap, h_sync, h_act;
    logic          v_wrap, v_sync, v_act;
    logic [CW-1:0] h_pos, v_pos;

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic          h_nlast, h_la_act, v_la_act;
    logic          v_nlast;
    logic [CW-1:0] h_la_pos, v_la_pos;
`endif

    vga_axis_counter #(
        .CW(CW), .SYNC(H_SYNC), .BP(H_BP),
        .ACTIVE(H_ACTIVE), .FP(H_FP)
    ) u_h (
        .dclk   (dclk),
        .clr_n  (clr_n),
        .adv    (ce),
`ifdef VGA_TIMING_LOOKAHEAD_EN
        .la_adv (1'b1),
        .nlast  (h_nlast),
        .la_act (h_la_act),
        .la_pos (h_la_pos),
`endif
        .cnt    (hc),
        .wrap   (h_wrap),
        .n_sync (h_sync),
        .n_act  (h_act),
        .n_pos  (h_pos)
    );

    vga_axis_counter #(
        .CW(CW), .SYNC(V_SYNC), .BP(V_BP),
        .ACTIVE(V_ACTIVE), .FP(V_FP)
    ) u_v (
        .dclk   (dclk),
        .clr_n  (clr_n),
        .adv    (h_wrap),
`ifdef VGA_TIMING_LOOKAHEAD_EN
        .la_adv (h_nlast),
        .nlast  (v_nlast),
        .la_act (v_la_act),
        .la_pos (v_la_pos),
`endif
        .cnt    (vc),
        .wrap   (v_wrap),
        .n_sync (v_sync),
        .n_act  (v_act),
        .n_pos  (v_pos)
    );

    // Everything is decoded from next-state counts, so it lines up with hc/vc.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            hsync       <= H_POL;
            vsync       <= V_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= h_sync ? H_POL : !H_POL;
            vsync       <= v_sync ? V_POL : !V_POL;
            de          <= h_act && v_act;
            x           <= (h_act && v_act) ? h_pos : '0;
            y           <= (h_act && v_act) ? v_pos : '0;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic unused_la;
    assign unused_la = v_nlast;

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            nde <= 1'b0;
            nx  <= '0;
            ny  <= '0;
        end else begin
            nde <= h_la_act && v_la_act;
            nx  <= (h_la_act && v_la_act) ? h_la_pos : '0;
            ny  <= (h_la_act && v_la_act) ? v_la_pos : '0;
        end
    end
`endif

endmodule
